crc_engine_arbiter: RTL

//  Shares one CRC check engine between the two bus-comparator channels.

---
 rtl/crc_engine_arbiter_if.sv | 35 +++
 rtl/crc_engine_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine_arbiter_if.sv
// Channel request/verdict and CRC engine handshake bundle for crc_engine_arbiter.
// master: channel capture logic plus engine; slave: the arbiter.
interface crc_engine_arbiter_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              req2;
    logic [DATA_W-1:0] data2;
    logic              grant1;
    logic              grant2;
    logic              done1;
    logic              done2;
    logic              ok1;
    logic              ok2;
    logic              to1;
    logic              to2;
    logic              eng_start;
    logic [DATA_W-1:0] eng_data;
    logic              eng_clr;
    logic              eng_done;
    logic              eng_ok;

    modport master (
        output req1, data1, req2, data2, eng_done, eng_ok,
        input  grant1, grant2, done1, done2, ok1, ok2, to1, to2,
        input  eng_start, eng_data, eng_clr
    );

    modport slave (
        input  req1, data1, req2, data2, eng_done, eng_ok,
        output grant1, grant2, done1, done2, ok1, ok2, to1, to2,
        output eng_start, eng_data, eng_clr
    );
endinterface

// File: rtl/crc_engine_arbiter.sv
// Round-robin sharing of one CRC check engine between two comparator channels.
// Optional engine watchdog enabled by defining CRC_TIMEOUT_EN.
module crc_engine_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TO_CYC = 255,
    parameter int unsigned TO_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    crc_engine_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_REPORT
    } state_t;

    // The watchdog counter must be able to hold the limit.
    if (64'(TO_CYC) >= (64'(1) << TO_W)) begin : g_bad_to_cfg
        $error("crc_engine_arbiter: TO_CYC must be < 2**TO_W");
    end

    state_t            r_state;
    logic              r_last2;
    logic              r_grant1;
    logic              r_grant2;
    logic              r_done1;
    logic              r_done2;
    logic              r_ok1;
    logic              r_ok2;
    logic              r_eng_start;
    logic [DATA_W-1:0] r_eng_data;

    logic w_pick1;
    logic w_pick2;

    // On a tie the channel not served last wins.
    assign w_pick1 = bus.req1 && (!bus.req2 || r_last2);
    assign w_pick2 = bus.req2 && (!bus.req1 || !r_last2);

`ifdef CRC_TIMEOUT_EN
    logic            r_to1;
    logic            r_to2;
    logic            r_eng_clr;
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last2     <= 1'b1;
            r_grant1    <= 1'b0;
            r_grant2    <= 1'b0;
            r_done1     <= 1'b0;
            r_done2     <= 1'b0;
            r_ok1       <= 1'b0;
            r_ok2       <= 1'b0;
            r_to1       <= 1'b0;
            r_to2       <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_clr   <= 1'b0;
            r_eng_data  <= '0;
            r_cnt       <= '0;
        end else begin
            r_eng_start <= 1'b0;
            r_eng_clr   <= 1'b0;
            r_done1     <= 1'b0;
            r_done2     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick1) begin
                        r_grant1    <= 1'b1;
                        r_last2     <= 1'b0;
                        r_eng_data  <= bus.data1;
                        r_eng_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end else if (w_pick2) begin
                        r_grant2    <= 1'b1;
                        r_last2     <= 1'b1;
                        r_eng_data  <= bus.data2;
                        r_eng_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (bus.eng_done) begin
                        if (r_grant1) begin
                            r_ok1   <= bus.eng_ok;
                            r_to1   <= 1'b0;
                            r_done1 <= 1'b1;
                        end else begin
                            r_ok2   <= bus.eng_ok;
                            r_to2   <= 1'b0;
                            r_done2 <= 1'b1;
                        end
                        r_state <= S_REPORT;
                    end else if (r_cnt == TO_W'(TO_CYC - 1)) begin
                        r_eng_clr <= 1'b1;
                        if (r_grant1) begin
                            r_ok1   <= 1'b0;
                            r_to1   <= 1'b1;
                            r_done1 <= 1'b1;
                        end else begin
                            r_ok2   <= 1'b0;
                            r_to2   <= 1'b1;
                            r_done2 <= 1'b1;
                        end
                        r_state <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                S_REPORT: begin
                    r_grant1 <= 1'b0;
                    r_grant2 <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.to1     = r_to1;
    assign bus.to2     = r_to2;
    assign bus.eng_clr = r_eng_clr;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last2     <= 1'b1;
            r_grant1    <= 1'b0;
            r_grant2    <= 1'b0;
            r_done1     <= 1'b0;
            r_done2     <= 1'b0;
            r_ok1       <= 1'b0;
            r_ok2       <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
        end else begin
            r_eng_start <= 1'b0;
            r_done1     <= 1'b0;
            r_done2     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick1) begin
                        r_grant1    <= 1'b1;
                        r_last2     <= 1'b0;
                        r_eng_data  <= bus.data1;
                        r_eng_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end else if (w_pick2) begin
                        r_grant2    <= 1'b1;
                        r_last2     <= 1'b1;
                        r_eng_data  <= bus.data2;
                        r_eng_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.eng_done) begin
                        if (r_grant1) begin
                            r_ok1   <= bus.eng_ok;
                            r_done1 <= 1'b1;
                        end else begin
                            r_ok2   <= bus.eng_ok;
                            r_done2 <= 1'b1;
                        end
                        r_state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_grant1 <= 1'b0;
                    r_grant2 <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.to1     = 1'b0;
    assign bus.to2     = 1'b0;
    assign bus.eng_clr = 1'b0;
`endif

    assign bus.grant1    = r_grant1;
    assign bus.grant2    = r_grant2;
    assign bus.done1     = r_done1;
    assign bus.done2     = r_done2;
    assign bus.ok1       = r_ok1;
    assign bus.ok2       = r_ok2;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_data  = r_eng_data;
endmodule
